// File: rtl/crc12_pkg.sv
// Shared constants, FSM encoding and output-register layout for the CRC-12 framer.
package crc12_pkg;

  localparam logic [11:0] CRC12_POLY = 12'h80F;
  localparam logic [11:0] CRC12_INIT = 12'h000;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StCrcHi,
    StCrcMid,
    StCrcLo
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] data;
    logic       is_crc;
    logic       last;
  } out_reg_t;

  localparam out_reg_t OUT_REG_RESET = '{valid: 1'b0, data: 4'h0, is_crc: 1'b0, last: 1'b0};

endpackage

// File: rtl/crc12_nibble_step.sv
// Combinational CRC-12 update for one nibble, processed MSB first.
module crc12_nibble_step
  import crc12_pkg::*;
(
  input  logic [11:0] crc,
  input  logic [3:0]  nib,
  output logic [11:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int i = 3; i >= 0; i--) begin
      if (crc_next[11] ^ nib[i]) begin
        crc_next = {crc_next[10:0], 1'b0} ^ CRC12_POLY;
      end else begin
        crc_next = {crc_next[10:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/crc12_frame_ctrl.sv
// Nibble-stream framer: passes data through and appends a 12-bit CRC as three trailing nibbles.
module crc12_frame_ctrl
  import crc12_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        out_is_crc,
  output logic        out_last,
  output logic        crc_done,
  output logic [11:0] crc_result,
  output logic [7:0]  frame_cnt,
  output logic        len_err
);

  // Counter holds up to MAX_LEN+1 so an over-long frame stays distinguishable.
  localparam int unsigned CntW = $clog2(MAX_LEN + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_LEN);
  localparam logic [CntW-1:0] CntSat = CntW'(MAX_LEN + 1);

  state_e          state_q, state_d;
  logic [11:0]     crc_q, crc_d, crc_step;
  out_reg_t        out_q, out_d;
  logic            crc_done_q, crc_done_d;
  logic [11:0]     crc_result_q, crc_result_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            len_err_q, len_err_d;
  logic [CntW-1:0] len_cnt_q, len_cnt_d;
  logic            advance, in_ready_c, accept;

  crc12_nibble_step u_step (
    .crc      (crc_q),
    .nib      (in_data),
    .crc_next (crc_step)
  );

  always_comb begin
    advance    = !out_q.valid || out_ready;
    in_ready_c = !rst && advance && (state_q == StIdle || state_q == StData);
    accept     = in_valid && in_ready_c;

    state_d      = state_q;
    crc_d        = crc_q;
    out_d        = out_q;
    crc_done_d   = 1'b0;
    crc_result_d = crc_result_q;
    frame_cnt_d  = frame_cnt_q;
    len_err_d    = len_err_q;
    len_cnt_d    = len_cnt_q;

    unique case (state_q)
      StIdle, StData: begin
        if (accept) begin
          out_d = '{valid: 1'b1, data: in_data, is_crc: 1'b0, last: 1'b0};
          crc_d = crc_step;
          if (len_cnt_q >= CntMax) begin
            len_err_d = 1'b1;
          end
          if (in_last) begin
            state_d   = StCrcHi;
            len_cnt_d = '0;
          end else begin
            state_d = StData;
            if (len_cnt_q != CntSat) begin
              len_cnt_d = len_cnt_q + CntW'(1);
            end
          end
        end else if (advance) begin
          out_d.valid = 1'b0;
        end
      end
      StCrcHi: begin
        if (advance) begin
          out_d   = '{valid: 1'b1, data: crc_q[11:8], is_crc: 1'b1, last: 1'b0};
          state_d = StCrcMid;
        end
      end
      StCrcMid: begin
        if (advance) begin
          out_d   = '{valid: 1'b1, data: crc_q[7:4], is_crc: 1'b1, last: 1'b0};
          state_d = StCrcLo;
        end
      end
      StCrcLo: begin
        if (advance) begin
          out_d        = '{valid: 1'b1, data: crc_q[3:0], is_crc: 1'b1, last: 1'b1};
          state_d      = StIdle;
          crc_d        = CRC12_INIT;
          crc_result_d = crc_q;
          crc_done_d   = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      crc_q        <= CRC12_INIT;
      out_q        <= OUT_REG_RESET;
      crc_done_q   <= 1'b0;
      crc_result_q <= '0;
      frame_cnt_q  <= '0;
      len_err_q    <= 1'b0;
      len_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      out_q        <= out_d;
      crc_done_q   <= crc_done_d;
      crc_result_q <= crc_result_d;
      frame_cnt_q  <= frame_cnt_d;
      len_err_q    <= len_err_d;
      len_cnt_q    <= len_cnt_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign out_valid  = out_q.valid;
  assign out_data   = out_q.data;
  assign out_is_crc = out_q.is_crc;
  assign out_last   = out_q.last;
  assign crc_done   = crc_done_q;
  assign crc_result = crc_result_q;
  assign frame_cnt  = frame_cnt_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_crc12_frame_ctrl.sv
// Bench for crc12_frame_ctrl: directed frames plus randomized traffic against a stream model.
module tb_crc12_frame_ctrl;

  localparam int unsigned MaxLen = 4;

  typedef struct packed {
    logic [3:0] data;
    logic       is_crc;
    logic       last;
  } item_t;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
  } src_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = 4'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic        out_is_crc;
  logic        out_last;
  logic        crc_done;
  logic [11:0] crc_result;
  logic [7:0]  frame_cnt;
  logic        len_err;

  always #5 clk = ~clk;

  crc12_frame_ctrl #(.MAX_LEN(MaxLen)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_is_crc (out_is_crc),
    .out_last   (out_last),
    .crc_done   (crc_done),
    .crc_result (crc_result),
    .frame_cnt  (frame_cnt),
    .len_err    (len_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus and model state
  src_t        src_q[$];
  item_t       exp_q[$];
  logic [11:0] crc_exp_q[$];
  logic [3:0]  cur[$];
  logic        force_rst = 1'b1;
  int          rdy_pct = 100;
  int          gap_pct = 0;
  int          stall = 0;
  logic        exp_len_err = 1'b0;
  int          exp_frames = 0;
  logic [11:0] exp_result = 12'h000;
  logic        crc_phase = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic        prev_acc = 1'b0;
  item_t       held = '0;
  int          blocked_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] obs_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference CRC as the remainder of M(x)*x^12 divided by the generator polynomial.
  function automatic logic [11:0] crc_ref(input logic [3:0] nibs[$]);
    logic [139:0] m;
    int nb;
    m  = '0;
    nb = nibs.size() * 4;
    foreach (nibs[i]) m = {m[135:0], nibs[i]};
    m = m << 12;
    for (int b = nb + 11; b >= 12; b--) begin
      if (m[b]) m = m ^ (140'h180F << (b - 12));
    end
    return m[11:0];
  endfunction

  task automatic step();
    logic  acc, hs, fresh, exp_done;
    item_t it;
    logic [11:0] c;
    @(negedge clk);
    rst = force_rst;
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = ($urandom_range(99) < rdy_pct);
    end
    if (src_q.size() != 0 && $urandom_range(99) >= gap_pct) begin
      in_valid = 1'b1;
      in_data  = src_q[0].d;
      in_last  = src_q[0].l;
    end else begin
      in_valid = 1'b0;
      in_data  = 4'($urandom_range(15));
      in_last  = 1'($urandom_range(1));
    end
    #1;
    acc      = in_valid && in_ready;
    hs       = out_valid && out_ready;
    fresh    = !prev_valid || prev_hs;
    exp_done = 1'b0;

    if (prev_acc) check("latency_out_valid", 32'(out_valid), 32'd1);
    if (out_valid && fresh) begin
      check("out_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(it.data));
        check("out_is_crc", 32'(out_is_crc), 32'(it.is_crc));
        check("out_last", 32'(out_last), 32'(it.last));
        held     = it;
        exp_done = it.last;
      end
    end else if (out_valid) begin
      check("stall_data", 32'(out_data), 32'(held.data));
      check("stall_is_crc", 32'(out_is_crc), 32'(held.is_crc));
      check("stall_last", 32'(out_last), 32'(held.last));
    end
    if (exp_done) begin
      exp_frames = (exp_frames + 1) % 256;
      if (crc_exp_q.size() != 0) exp_result = crc_exp_q.pop_front();
      crc_phase = 1'b0;
    end
    check("in_ready", 32'(in_ready), 32'(!rst && (!out_valid || out_ready) && !crc_phase));
    check("crc_done", 32'(crc_done), 32'(exp_done));
    check("crc_result", 32'(crc_result), 32'(exp_result));
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("len_err", 32'(len_err), 32'(exp_len_err));

    if (hs) obs_word = {obs_word[27:0], out_data};
    if (in_valid && !in_ready && !rst) blocked_cnt++;
    if (crc_done) done_cnt++;

    if (acc) begin
      exp_q.push_back({in_data, 1'b0, 1'b0});
      cur.push_back(in_data);
      if (cur.size() > MaxLen) exp_len_err = 1'b1;
      void'(src_q.pop_front());
      if (in_last) begin
        c = crc_ref(cur);
        exp_q.push_back({c[11:8], 1'b1, 1'b0});
        exp_q.push_back({c[7:4], 1'b1, 1'b0});
        exp_q.push_back({c[3:0], 1'b1, 1'b1});
        crc_exp_q.push_back(c);
        cur.delete();
        crc_phase = 1'b1;
      end
    end
    prev_valid = out_valid;
    prev_hs    = hs;
    prev_acc   = acc;
    if (rst) begin
      exp_q.delete();
      crc_exp_q.delete();
      cur.delete();
      src_q.delete();
      exp_len_err = 1'b0;
      exp_frames  = 0;
      exp_result  = 12'h000;
      crc_phase   = 1'b0;
      prev_valid  = 1'b0;
      prev_hs     = 1'b0;
      prev_acc    = 1'b0;
    end
  endtask

  task automatic do_reset();
    force_rst = 1'b1;
    repeat (2) step();
    force_rst = 1'b0;
    step();
  endtask

  task automatic push_frame(input logic [3:0] nibs[$]);
    foreach (nibs[i]) src_q.push_back({nibs[i], 1'(i == nibs.size() - 1)});
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    repeat (3) step();
    check("drain", 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  logic [3:0] fr[$];

  initial begin
    fr = {4'h1};          check("ref_crc_1", 32'(crc_ref(fr)), 32'h80F);
    fr = {4'h2};          check("ref_crc_2", 32'(crc_ref(fr)), 32'h811);
    fr = {4'h0};          check("ref_crc_0", 32'(crc_ref(fr)), 32'h000);
    fr = {4'h1, 4'h0};    check("ref_crc_10", 32'(crc_ref(fr)), 32'h8A5);

    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_crc_result", 32'(crc_result), 32'd0);

    // Single-nibble frames
    rdy_pct = 100; gap_pct = 0;
    obs_word = '0; fr = {4'h1}; push_frame(fr); drain(50);
    check("f1_stream", obs_word, 32'h180F);
    check("f1_crc", 32'(crc_result), 32'h80F);
    check("f1_cnt", 32'(frame_cnt), 32'd1);
    obs_word = '0; fr = {4'h2}; push_frame(fr); drain(50);
    check("f2_stream", obs_word, 32'h2811);
    check("f2_crc", 32'(crc_result), 32'h811);
    obs_word = 32'hFFFF_FFFF; fr = {4'h0}; push_frame(fr); drain(50);
    check("f0_stream", obs_word, 32'hFFFF_0000);
    check("f0_crc", 32'(crc_result), 32'h000);

    // Stall three cycles after the first nibble
    obs_word = '0; fr = {4'h1, 4'h0}; push_frame(fr);
    for (int i = 0; i < 20 && src_q.size() > 1; i++) step();
    stall = 3;
    drain(50);
    check("f10_stream", obs_word, 32'h108A5);
    check("f10_crc", 32'(crc_result), 32'h8A5);

    // Back-to-back frames with in_valid held
    do_reset();
    blocked_cnt = 0; done_cnt = 0;
    fr = {4'h1}; push_frame(fr);
    fr = {4'h2}; push_frame(fr);
    drain(50);
    check("b2b_blocked", 32'(blocked_cnt), 32'd3);
    check("b2b_done", 32'(done_cnt), 32'd2);
    check("b2b_cnt", 32'(frame_cnt), 32'd2);

    // Reset mid-frame
    do_reset();
    done_cnt = 0;
    fr = {4'h3, 4'h4, 4'h5, 4'h6}; push_frame(fr);
    for (int i = 0; i < 20 && src_q.size() > 2; i++) step();
    do_reset();
    check("midrst_done", 32'(done_cnt), 32'd0);
    fr = {4'h1}; push_frame(fr); drain(50);
    check("midrst_crc", 32'(crc_result), 32'h80F);
    check("midrst_cnt", 32'(frame_cnt), 32'd1);

    // Length limit
    fr = {4'h9, 4'h8, 4'h7, 4'h6}; push_frame(fr); drain(50);
    check("len_ok_4", 32'(len_err), 32'd0);
    fr = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5}; push_frame(fr);
    for (int i = 0; i < 50 && src_q.size() > 0; i++) step();
    step();
    check("len_err_set", 32'(len_err), 32'd1);
    drain(50);

    // Randomized traffic
    rdy_pct = 70; gap_pct = 20;
    for (int f = 0; f < 40; f++) begin
      fr.delete();
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) fr.push_back(4'($urandom_range(15)));
      push_frame(fr);
    end
    for (int i = 0; i < 3000 && (src_q.size() != 0 || exp_q.size() != 0); i++) begin
      if ($urandom_range(31) == 0) stall = int'($urandom_range(4, 1));
      step();
    end
    rdy_pct = 100;
    drain(100);
    check("len_err_sticky", 32'(len_err), 32'd1);

    do_reset();
    check("len_err_cleared", 32'(len_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/crc12_frame_ctrl.md
CRC12_FRAME_CTRL -- requirements
Module: crc12_frame_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256, meaning the maximum data nibbles per frame before len_err is set.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: a data nibble is offered.
REQ-005 SHALL have port in_ready, output, 1: the nibble is accepted this cycle when in_valid=1.
REQ-006 SHALL have port in_data, input, 4: the data nibble.
REQ-007 SHALL have port in_last, input, 1: the offered nibble is the last of its frame.
REQ-008 SHALL have port out_valid, output, 1: out_data is presented.
REQ-009 SHALL have port out_ready, input, 1: the downstream accepts the output this cycle.
REQ-010 SHALL have port out_data, output, 4: a passthrough data nibble or a CRC nibble.
REQ-011 SHALL have port out_is_crc, output, 1: out_data is a CRC nibble.
REQ-012 SHALL have port out_last, output, 1: out_data is the final nibble of the frame, which is always CRC bits [3:0].
REQ-013 SHALL have port crc_done, output, 1: one-cycle pulse when a frame completes.
REQ-014 SHALL have port crc_result, output, 12: the CRC of the last completed frame, held until the next completion.
REQ-015 SHALL have port frame_cnt, output, 8: completed frames, wrapping 255->0.
REQ-016 SHALL have port len_err, output, 1: sticky flag, set when any frame exceeds MAX_LEN data nibbles.

Function
REQ-017 SHALL use CRC polynomial x^12+x^11+x^3+x^2+x+1 (0x80F) with init 0, no reflection and no final XOR.
REQ-018 SHALL update the CRC per nibble, MSB first, four bit steps per cycle; each step computes fb = crc[11]^d, then crc = {crc[10:0],0} ^ (fb ? 0x80F : 0).
REQ-019 SHALL use FSM states IDLE, DATA, CRC_HI, CRC_MID and CRC_LO.
REQ-020 SHALL define advance = !out_valid | out_ready; the output register loads only when advance=1.
REQ-021 SHALL, in IDLE and DATA, drive in_ready = advance; in the three CRC states it SHALL drive in_ready = 0.
REQ-022 SHALL, on accept (in_valid & in_ready), load the output register with out_data=in_data, out_valid=1, out_is_crc=0 and out_last=0, and update the CRC register with the stepped value.
REQ-023 SHALL have one-cycle latency from accept to out_valid.
REQ-024 SHALL transition on an accept with in_last=0 from IDLE or DATA to DATA.
REQ-025 SHALL transition on an accept with in_last=1 to CRC_HI; a 1-nibble frame goes IDLE->CRC_HI directly.
REQ-026 SHALL, in IDLE or DATA with advance=1 and no accept, clear out_valid and hold the state.
REQ-027 SHALL, in CRC_HI with advance=1, load out_data=crc[11:8] with out_is_crc=1 and go to CRC_MID.
REQ-028 SHALL, in CRC_MID with advance=1, load crc[7:4] and go to CRC_LO.
REQ-029 SHALL, in CRC_LO with advance=1, load crc[3:0] with out_last=1 and return to IDLE.
REQ-030 SHALL, in the same CRC_LO cycle, clear the CRC register to 0, copy it to crc_result, pulse crc_done and increment frame_cnt.
REQ-031 SHALL emit N+3 output nibbles for a frame of N data nibbles.
REQ-032 SHALL hold out_data, out_is_crc and out_last stable while out_valid=1 and out_ready=0.
REQ-033 SHALL track the data-nibble count of each frame and saturate it at MAX_LEN+1.
REQ-034 SHALL set len_err when an accepted nibble would make the count exceed MAX_LEN; the frame is still processed normally.
REQ-035 SHALL clear len_err only on rst.
REQ-036 SHALL hold the next frame's first nibble while in a CRC state; it is accepted once IDLE is reached, with no nibble loss.

Reset
REQ-037 SHALL, on rst=1 at a clock edge, set state=IDLE, crc=0, out_valid=0, out_data=0, out_is_crc=0, out_last=0, crc_done=0, crc_result=0, frame_cnt=0, len_err=0 and the length counter to 0.
REQ-038 SHALL, when rst is asserted mid-frame, discard the partial frame with no CRC emitted and no crc_done.
REQ-039 SHALL drive in_ready=0 while rst=1.

Structure
REQ-040 SHALL place CRC12_POLY=12'h80F, CRC12_INIT=12'h000 and the FSM state encoding in shared package crc12_pkg.
REQ-041 SHALL implement the one-nibble CRC step as combinational sub-module crc12_nibble_step (inputs crc[11:0] and nib[3:0], output crc_next[11:0]), instantiated once.

Verification
REQ-042 SHALL cover: frame {0x1}, out_ready=1 -> outputs 1, 8, 0, F; out_last on F; crc_result=0x80F; frame_cnt=1.
REQ-043 SHALL cover: frame {0x2} -> CRC nibbles 8, 1, 1; crc_result=0x811. Frame {0x0} -> CRC nibbles 0, 0, 0.
REQ-044 SHALL cover: frame {0x1, 0x0} with out_ready low for 3 cycles mid-frame -> outputs 1, 0, 8, A, 5; outputs stable while stalled; crc_result=0x8A5.
REQ-045 SHALL cover: back-to-back frames {0x1} then {0x2} with in_valid held high -> in_ready=0 for three cycles between frames; crc_done pulses twice; frame_cnt=2.
REQ-046 SHALL cover: rst pulsed after 2 nibbles of a frame -> no CRC out; restarted frame {0x1} yields 0x80F; frame_cnt=1.
REQ-047 SHALL cover: MAX_LEN=4 with a 5-nibble frame -> len_err=1 after the 5th accept; CRC still emitted; len_err stays 1 until rst.
